// File: rtl/acc_cpu_pkg.sv
// Shared types for the accumulator core: opcode and FSM encodings, and a
// constant-foldable clog2 used to size address fields.
package acc_cpu_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_LDI  = 4'h0,
      OP_MOV  = 4'h1,
      OP_ADD  = 4'h2,
      OP_SUB  = 4'h3,
      OP_AND  = 4'h4,
      OP_OR   = 4'h5,
      OP_SHR  = 4'h6,
      OP_SHL  = 4'h7,
      OP_ST   = 4'h8,
      OP_LD   = 4'h9,
      OP_ACC  = 4'hA,
      OP_CLRA = 4'hB
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      MEMRD = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/acc_cpu_regfile.sv
// NREGS x DATA_W register file: two async read ports, one sync write port.
// Write lands on the next clock edge; synchronous clear has priority.
module acc_cpu_regfile
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NREGS  = 8,
   parameter int RA_W   = clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [RA_W-1:0]   waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [RA_W-1:0]   raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [RA_W-1:0]   raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator core; SHR/SHL exist only when BARREL_SHIFT_EN is defined.
// ALU/ST take 2 cycles and LD 3 from accept to ready; instr_valid is ignored while busy.
module acc_cpu_core
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NREGS     = 8,
   parameter int MEM_DEPTH = 16,
   parameter int PC_W      = 8,
   localparam int RA_W     = clog2(NREGS),
   localparam int MA_W     = clog2(MEM_DEPTH),
   localparam int IW       = OP_W + 2*RA_W + DATA_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [IW-1:0]     INSTRUCTION,
   output logic [PC_W-1:0]   PC,
   output logic [DATA_W-1:0] acc_out,
   output logic              zero,
   output logic              carry,
   output logic              illegal,
   output logic              busy
);

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [RA_W-1:0]   dst;
      logic [RA_W-1:0]   src;
      logic [DATA_W-1:0] imm;
   } instr_t;

   state_e            state;
   instr_t            ir;
   logic [DATA_W-1:0] mem [MEM_DEPTH];
   logic [DATA_W-1:0] mem_rd;
   logic [DATA_W-1:0] rd, rs, res, acc_nxt;
   logic [DATA_W:0]   add_sum, sub_sum, acc_sum;
   logic [MA_W-1:0]   maddr;
   logic              exec, reg_we, acc_we, mem_we, z_upd, c_upd, c_nxt, z_nxt, bad;

   assign exec        = (state == EXEC);
   assign instr_ready = (state == IDLE);
   assign busy        = !instr_ready;
   assign illegal     = exec && bad;
   assign maddr       = ir.imm[MA_W-1:0];

   acc_cpu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .RA_W(RA_W)) u_regfile (
      .clk     (CLK),
      .reset   (RESET),
      .we      ((exec && reg_we) || (state == MEMRD)),
      .waddr   (ir.dst),
      .wdata   ((state == MEMRD) ? mem_rd : res),
      .raddr_a (ir.dst),
      .rdata_a (rd),
      .raddr_b (ir.src),
      .rdata_b (rs)
   );

   // SUB is done as Rd + ~Rs + 1 so the carry-out reads as "no borrow".
   assign add_sum = {1'b0, rd} + {1'b0, rs};
   assign sub_sum = {1'b0, rd} + {1'b0, ~rs} + {{DATA_W{1'b0}}, 1'b1};
   assign acc_sum = {1'b0, acc_out} + {1'b0, rs};

`ifdef BARREL_SHIFT_EN
   localparam int SH_W = clog2(DATA_W);
   logic [DATA_W-1:0] shr_res, shl_res;

   always_comb begin
      shr_res = rd;
      shl_res = rd;
      for (int s = 0; s < SH_W; s++) begin
         if (ir.imm[s]) begin
            shr_res = shr_res >> (1 << s);
            shl_res = shl_res << (1 << s);
         end
      end
   end
`endif

   always_comb begin
      res     = '0;
      acc_nxt = acc_out;
      c_nxt   = carry;
      reg_we  = 1'b0;
      acc_we  = 1'b0;
      mem_we  = 1'b0;
      z_upd   = 1'b0;
      c_upd   = 1'b0;
      bad     = 1'b0;
      case (ir.op)
         OP_LDI:  begin res = ir.imm; reg_we = 1'b1; end
         OP_MOV:  begin res = rs;     reg_we = 1'b1; end
         OP_ADD:  begin {c_nxt, res} = add_sum; reg_we = 1'b1; z_upd = 1'b1; c_upd = 1'b1; end
         OP_SUB:  begin {c_nxt, res} = sub_sum; reg_we = 1'b1; z_upd = 1'b1; c_upd = 1'b1; end
         OP_AND:  begin res = rd & rs; reg_we = 1'b1; z_upd = 1'b1; end
         OP_OR:   begin res = rd | rs; reg_we = 1'b1; z_upd = 1'b1; end
`ifdef BARREL_SHIFT_EN
         OP_SHR:  begin res = shr_res; reg_we = 1'b1; z_upd = 1'b1; end
         OP_SHL:  begin res = shl_res; reg_we = 1'b1; z_upd = 1'b1; end
`endif
         OP_ST:   mem_we = 1'b1;
         OP_LD:   ;
         OP_ACC:  begin {c_nxt, acc_nxt} = acc_sum; acc_we = 1'b1; z_upd = 1'b1; c_upd = 1'b1; end
         OP_CLRA: begin acc_nxt = '0; acc_we = 1'b1; end
         default: bad = 1'b1;
      endcase
   end

   assign z_nxt = (ir.op == OP_ACC) ? (acc_nxt == '0) : (res == '0);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= IDLE;
         ir      <= '0;
         PC      <= '0;
         acc_out <= '0;
         zero    <= 1'b0;
         carry   <= 1'b0;
         mem_rd  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  ir    <= INSTRUCTION;
                  PC    <= PC + PC_W'(1);
                  state <= EXEC;
               end
            end
            EXEC: begin
               state  <= (ir.op == OP_LD) ? MEMRD : IDLE;
               mem_rd <= mem[maddr];
               if (acc_we) acc_out <= acc_nxt;
               if (z_upd)  zero    <= z_nxt;
               if (c_upd)  carry   <= c_nxt;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else if (exec && mem_we) begin
         mem[maddr] <= rs;
      end
   end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core: a behavioural ISA model predicts each
// instruction's outcome, which is compared when the core returns to ready.
module tb_acc_cpu_core;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        instr_valid, instr_ready, zero, carry, illegal, busy;
   logic [17:0] instruction;
   logic [7:0]  pc, acc;

   logic        v16, r16, z16, c16, i16, b16;
   logic [27:0] ins16;
   logic [7:0]  pc16;
   logic [15:0] acc16;

   acc_cpu_core dut (
      .CLK(clk), .RESET(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .INSTRUCTION(instruction), .PC(pc), .acc_out(acc), .zero(zero), .carry(carry),
      .illegal(illegal), .busy(busy));

   acc_cpu_core #(.DATA_W(16), .NREGS(16)) dut16 (
      .CLK(clk), .RESET(rst), .instr_valid(v16), .instr_ready(r16),
      .INSTRUCTION(ins16), .PC(pc16), .acc_out(acc16), .zero(z16), .carry(c16),
      .illegal(i16), .busy(b16));

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [7:0] acc;
      logic       z, c, ill;
      logic [7:0] pc;
      int         lat;
   } exp_t;

   typedef struct {
      logic [15:0] acc;
      logic        c;
   } exp16_t;

   exp_t   sb[$];
   exp16_t sb16[$];

   logic [7:0] m_reg [8];
   logic [7:0] m_mem [16];
   logic [7:0] m_acc, m_pc;
   logic       m_z, m_c;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_acc = 8'h00; m_pc = 8'h00; m_z = 1'b0; m_c = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] src,
                             input logic [7:0] imm, output exp_t e);
      logic [7:0] a, b;
      logic [8:0] t;
      a = m_reg[dst];
      b = m_reg[src];
      e.ill = 1'b0;
      e.lat = 2;
      case (op)
         4'h0: m_reg[dst] = imm;
         4'h1: m_reg[dst] = b;
         4'h2: begin t = a + b; m_reg[dst] = t[7:0]; m_c = t[8]; m_z = (t[7:0] == 0); end
         4'h3: begin m_reg[dst] = a - b; m_c = (a >= b); m_z = (a == b); end
         4'h4: begin m_reg[dst] = a & b; m_z = ((a & b) == 0); end
         4'h5: begin m_reg[dst] = a | b; m_z = ((a | b) == 0); end
`ifdef BARREL_SHIFT_EN
         4'h6: begin m_reg[dst] = a >> imm[2:0]; m_z = ((a >> imm[2:0]) == 0); end
         4'h7: begin m_reg[dst] = a << imm[2:0]; m_z = (8'(a << imm[2:0]) == 0); end
`endif
         4'h8: m_mem[imm[3:0]] = b;
         4'h9: begin m_reg[dst] = m_mem[imm[3:0]]; e.lat = 3; end
         4'hA: begin t = m_acc + b; m_acc = t[7:0]; m_c = t[8]; m_z = (t[7:0] == 0); end
         4'hB: m_acc = 8'h00;
         default: e.ill = 1'b1;
      endcase
      m_pc  = m_pc + 8'd1;
      e.acc = m_acc; e.z = m_z; e.c = m_c; e.pc = m_pc;
   endtask

   task automatic issue(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] src,
                        input logic [7:0] imm, input bit hold = 1'b0);
      exp_t e, x;
      int   n;
      @(negedge clk);
      n = 0;
      while (!instr_ready && n < 20) begin @(negedge clk); n++; end
      check("ready_before_issue", instr_ready, 1'b1);
      instr_valid = 1'b1;
      instruction = {op, dst, src, imm};
      model_step(op, dst, src, imm, e);
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (!hold) instr_valid = 1'b0;
      x = sb.pop_front();
      check("busy_exec", busy, 1'b1);
      check("illegal_exec", illegal, x.ill);
      n = 1;
      while (!instr_ready && n < 10) begin @(negedge clk); n++; end
      instr_valid = 1'b0;
      check("latency", n, x.lat);
      check("illegal_after", illegal, 1'b0);
      check("acc", acc, x.acc);
      check("zero", zero, x.z);
      check("carry", carry, x.c);
      check("pc", pc, x.pc);
   endtask

   // Registers are only visible through the accumulator.
   task automatic peek(input logic [2:0] r);
      issue(4'hB, 3'd0, 3'd0, 8'h00);
      issue(4'hA, 3'd0, r, 8'h00);
   endtask

   task automatic issue16(input logic [3:0] op, input logic [3:0] dst, input logic [3:0] src,
                          input logic [15:0] imm, input logic [15:0] exp_acc, input logic exp_c);
      exp16_t x;
      int     n;
      sb16.push_back('{acc: exp_acc, c: exp_c});
      @(negedge clk);
      v16   = 1'b1;
      ins16 = {op, dst, src, imm};
      @(posedge clk);
      @(negedge clk);
      v16 = 1'b0;
      n = 1;
      while (!r16 && n < 10) begin @(negedge clk); n++; end
      x = sb16.pop_front();
      check("latency16", n, 2);
      check("acc16", acc16, x.acc);
      check("carry16", c16, x.c);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, instr_ready, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_pc"}, pc, 8'h00);
      check({tag, "_acc"}, acc, 8'h00);
      check({tag, "_zero"}, zero, 1'b0);
      check({tag, "_carry"}, carry, 1'b0);
      check({tag, "_illegal"}, illegal, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instruction = '0; v16 = 1'b0; ins16 = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      check("reset16_acc", acc16, 16'h0000);
      check("reset16_pc", pc16, 8'h00);
      rst = 1'b0;

      // Basic add.
      issue(4'h0, 3'd1, 3'd0, 8'h05);
      issue(4'h0, 3'd2, 3'd0, 8'h03);
      issue(4'h2, 3'd1, 3'd2, 8'h00);
      peek(3'd1);

      // Wrap-around add and self-subtract.
      issue(4'h0, 3'd1, 3'd0, 8'hFF);
      issue(4'h0, 3'd2, 3'd0, 8'h01);
      issue(4'h2, 3'd1, 3'd2, 8'h00);
      issue(4'h3, 3'd2, 3'd2, 8'h00);
      peek(3'd2);

      // Store/load with address wrap.
      issue(4'h0, 3'd3, 3'd0, 8'hA5);
      issue(4'h8, 3'd0, 3'd3, 8'h13);
      issue(4'h9, 3'd4, 3'd0, 8'h03);
      peek(3'd4);

      // Shifts (illegal when the shifter is not built).
      issue(4'h0, 3'd1, 3'd0, 8'h81);
      issue(4'h6, 3'd1, 3'd0, 8'h03);
      peek(3'd1);
      issue(4'h7, 3'd1, 3'd0, 8'h04);
      peek(3'd1);

      // Undefined opcode, then valid held high across busy.
      issue(4'hE, 3'd1, 3'd2, 8'h55);
      issue(4'h0, 3'd6, 3'd0, 8'h3C, 1'b1);
      peek(3'd6);

      // Random instruction mix.
      for (int k = 0; k < 60; k++) begin
         issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
         if (k % 8 == 7) peek(3'($urandom_range(0, 7)));
      end

      // Reset arriving while a load is in its RAM-read cycle.
      issue(4'h0, 3'd5, 3'd0, 8'h77);
      issue(4'h8, 3'd0, 3'd3, 8'h03);
      @(negedge clk);
      instr_valid = 1'b1;
      instruction = {4'h9, 3'd5, 3'd0, 8'h03};
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      check("memrd_busy", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("memrd_reset");
      rst = 1'b0;
      model_reset();
      peek(3'd5);
      issue(4'h9, 3'd5, 3'd0, 8'h03);
      peek(3'd5);

      // 16-bit / 16-register instance: accumulator overflow.
      issue16(4'h0, 4'd15, 4'd0, 16'hFFFF, 16'h0000, 1'b0);
      issue16(4'h0, 4'd0,  4'd0, 16'h0001, 16'h0000, 1'b0);
      issue16(4'hA, 4'd0, 4'd15, 16'h0000, 16'hFFFF, 1'b0);
      issue16(4'hA, 4'd0, 4'd0,  16'h0000, 16'h0000, 1'b1);
      check("zero16", z16, 1'b1);
      check("pc16", pc16, 8'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
Parametrised successor to the 8-bit accumulator CPU. It is a multi-cycle core with an instruction-accept handshake, a generic-width register file, an ALU with carry and zero flags, an optional barrel shifter and an internal scratch RAM. Instructions are streamed in by the top-level wrapper, one at a time. Results are observable on the accumulator, program-counter and flag outputs.

Parameters:
DATA_W, 8, datapath width (4..32)
NREGS, 8, register count, power of 2 (2..16); RA_W = clog2(NREGS)
MEM_DEPTH, 16, scratch RAM words, power of 2, at most 2**DATA_W; MA_W = clog2(MEM_DEPTH)
PC_W, 8, program-counter width

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  core can accept an instruction
INSTRUCTION  in  4+2*RA_W+DATA_W  {op[3:0], dst, src, imm}
PC  out  PC_W  count of accepted instructions
acc_out  out  DATA_W  accumulator
zero  out  1  last ALU result == 0
carry  out  1  carry/borrow from last ADD/SUB/ACC
illegal  out  1  1-cycle pulse when an undefined op is accepted
busy  out  1  equals !instr_ready

Behaviour:
- Reset, applied synchronously on CLK:
  - instr_ready=1, PC=0, acc_out=0, zero=0, carry=0, illegal=0.
  - All registers and RAM words = 0.
  - FSM = IDLE.
  - RESET has priority over everything, including an in-flight instruction, which is discarded with no writeback.
- FSM states and transitions:
  - IDLE: instr_ready=1. When instr_valid&instr_ready, latch INSTRUCTION, PC<=PC+1 (wraps modulo 2**PC_W), go to EXEC.
  - EXEC: read operands, compute, update flags. ALU ops write back here and return to IDLE. LD issues the RAM read and goes to MEMRD. ST writes the RAM and returns to IDLE.
  - MEMRD: write the RAM data to reg[dst], return to IDLE.
- Throughput: ALU and ST ops take 2 cycles, accept to next instr_ready. LD takes 3 cycles.
- Result visibility: reg and acc results are visible the cycle after EXEC.
- Opcodes (Rd=reg[dst], Rs=reg[src]):
  - 0 LDI: Rd=imm.
  - 1 MOV: Rd=Rs.
  - 2 ADD: Rd=Rd+Rs.
  - 3 SUB: Rd=Rd-Rs, computed as Rd+~Rs+1.
  - 4 AND: Rd=Rd&Rs.
  - 5 OR: Rd=Rd|Rs.
  - 6 SHR: logical shift right of Rd by imm[clog2(DATA_W)-1:0].
  - 7 SHL: logical shift left, same shift amount.
  - 8 ST: mem[imm[MA_W-1:0]]=Rs.
  - 9 LD: Rd=mem[imm[MA_W-1:0]].
  - A ACC: acc=acc+Rs.
  - B CLRA: acc=0.
  - C-F: illegal. Treated as NOP with an illegal pulse in EXEC; PC still increments.
- Arithmetic: all results truncated to DATA_W.
  - carry is the DATA_W+1 bit of ADD/ACC.
  - For SUB, carry=1 means no borrow.
- Flags:
  - zero is updated by ops 2-7 and A.
  - carry is updated by ops 2, 3 and A only.
  - Other ops leave both flags unchanged.
- Operand aliasing: dst==src is legal and uses the pre-write value, e.g. SUB R1,R1 gives 0 with zero=1, carry=1.
- RAM address: the out-of-range high bits of imm are ignored, so addresses wrap.
- Handshake: instr_valid while busy is ignored. No buffering; the source must hold the instruction until it is accepted.

Optional Feature:
BARREL_SHIFT_EN
- Defined: SHR/SHL implemented as a log2(DATA_W)-stage mux barrel shifter in a single EXEC cycle.
- Undefined: opcodes 6/7 are illegal (illegal pulse, no writeback, flags unchanged) and no shifter logic is built.

Decomposition:
- Package acc_cpu_pkg holds:
  - the opcode enum (OP_LDI..OP_CLRA);
  - the FSM state enum (IDLE, EXEC, MEMRD);
  - the function clog2;
  - the constant OP_W=4.
- Sub-module acc_cpu_regfile:
  - NREGS x DATA_W storage;
  - two asynchronous read ports and one synchronous write port;
  - synchronous clear on RESET.

Test Plan:
1. Reset, then LDI R1,0x05; LDI R2,0x03; ADD R1,R2 -> R1=0x08, zero=0, carry=0, PC=3; instr_ready drops for exactly 1 cycle per instruction.
2. LDI R1,0xFF; LDI R2,0x01; ADD R1,R2 -> R1=0x00, zero=1, carry=1. Then SUB R2,R2 -> R2=0, carry=1.
3. LDI R3,0xA5; ST [0x13],R3; LD R4,[0x03] with MEM_DEPTH=16 -> R4=0xA5 (address wrap); LD busy for 2 cycles.
4. With BARREL_SHIFT_EN: LDI R1,0x81; SHR R1,imm=3 -> 0x10; SHL R1,imm=4 -> 0x00, zero=1. Without the macro: the same op pulses illegal and R1 stays 0x81.
5. Opcode 0xE accepted -> illegal high for 1 cycle, PC increments, registers unchanged. Then hold instr_valid high through busy -> no double accept.
6. Assert RESET during LD's MEMRD -> no writeback, all outputs at reset values the next cycle. Repeat with DATA_W=16, NREGS=16; ACC of 0xFFFF+0x0001 -> acc=0, carry=1.
